nvdla_glb_csb_arb: RTL and testbench
====================================

NVDLA_GLB_CSB_ARB -- requirements
Module: nvdla_glb_csb_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: response-wait limit in cycles (used only with timeout feature).
REQ-002 SHALL have parameter CNT_W, default 11: width of the timeout counter, sized to hold TIMEOUT_CYCLES.
REQ-003 nvdla_core_clk  in  1  sole clock, all state on rising edge.
REQ-004 nvdla_core_rst  in  1  asynchronous, active-high reset.
REQ-005 host_req_pvld / host_req_prdy / host_req_pd  in/out/in  1/1/63  requester 0 (external CSB master).
REQ-006 seq_req_pvld / seq_req_prdy / seq_req_pd  in/out/in  1/1/63  requester 1 (local layer sequencer).
REQ-007 csb2glb_req_pvld / csb2glb_req_prdy / csb2glb_req_pd  out/in/out  1/1/63  shared port to the global register block.
REQ-008 glb2csb_resp_valid / glb2csb_resp_pd  in/in  1/34  response from the global block.
REQ-009 host_resp_valid / host_resp_pd, seq_resp_valid / seq_resp_pd  out  1/34 each  routed responses.
REQ-010 arb_busy  out  1  high whenever state is not IDLE.
REQ-011 Request pd fields: [21:0] addr, [53:22] wdat, [54] write, [55] nposted. Response pd fields: [31:0] rdata, [32] error, [33] is_write.

Function
REQ-012 States: IDLE, ISSUE, WAIT_RESP.
REQ-013 IDLE: if any pvld, grant round-robin; on a tie, grant the requester not granted last; after reset, host has priority.
REQ-014 The granted requester's prdy SHALL be high combinationally in the IDLE cycle in which it is granted; all other prdy low; both prdy low outside IDLE.
REQ-015 On grant, pd SHALL be captured into a holding register, the owner recorded, and the next state set to ISSUE.
REQ-016 ISSUE: csb2glb_req_pvld = 1, csb2glb_req_pd = holding register (stable until accepted).
REQ-017 ISSUE with csb2glb_req_prdy = 1: if the request is a read or a non-posted write, go to WAIT_RESP; if it is a posted write, go to IDLE (no response expected).
REQ-018 WAIT_RESP: glb2csb_resp_valid SHALL be forwarded to the owner exactly one cycle later (registered): owner resp_valid = 1 for one cycle, resp_pd = captured glb2csb_resp_pd, then state returns to IDLE.
REQ-019 A glb2csb_resp_valid arriving in IDLE or ISSUE (spurious) SHALL be dropped and not forwarded.
REQ-020 Throughput: at most one transaction outstanding. Minimum cycles from grant to next grant: 2 for a posted write, 3 for a transaction with response.
REQ-021 A requester holding pvld SHALL never starve; round-robin guarantees a grant within 2 transactions.
REQ-022 Non-owner resp_valid SHALL remain 0 at all times.

Reset
REQ-023 Asserting reset SHALL move the state to IDLE, set last-grant to seq (so host wins first), and clear the holding register, timeout counter, and all outputs to 0: all resp_valid, resp_pd, csb2glb_req_pvld/pd, arb_busy.
REQ-024 Reset mid-transaction SHALL abandon it silently; no response is generated.

Configuration
REQ-025 Macro NVDLA_GLB_CSB_ARB_TIMEOUT_EN SHALL control the response timeout.
REQ-026 With the macro defined: the counter clears on entry to WAIT_RESP and increments each cycle. On reaching TIMEOUT_CYCLES with no response, the arbiter SHALL send the owner resp_pd with error = 1, rdata = 0, and is_write = request write bit, then return to IDLE. A response arriving in the same cycle as expiry wins; the error response is suppressed.
REQ-027 With the macro undefined: no counter logic is present, and WAIT_RESP waits indefinitely.

Structure
REQ-028 Shared package nvdla_glb_pkg SHALL hold the request and response field offsets/widths, the state enum, and the requester-ID constants (HOST = 0, SEQ = 1).
REQ-029 The round-robin select logic SHALL be a sub-module nvdla_glb_rr_arb2 (2 requesters, last-grant input, one-hot grant output); everything else is inline.

Verification
REQ-030 Host read at addr 0x000004, glb responds after 3 cycles with rdata 0xDEADBEEF -> host_resp_valid for 1 cycle with pd[31:0] = 0xDEADBEEF; seq_resp_valid stays 0.
REQ-031 Both pvld high continuously with posted writes -> grants alternate host, seq, host, seq; one grant every 2 cycles with csb2glb_req_prdy = 1.
REQ-032 csb2glb_req_prdy held low 5 cycles in ISSUE -> csb2glb_req_pd stays constant and both requester prdy stay 0.
REQ-033 Spurious glb2csb_resp_valid in IDLE -> no resp_valid on either requester.
REQ-034 Reset asserted in WAIT_RESP, then a glb response arrives -> no forwarded response, and the host is granted first after reset.
REQ-035 With the TIMEOUT_EN macro and TIMEOUT_CYCLES = 16, a seq non-posted write with no response -> seq_resp_valid 16 cycles after WAIT_RESP entry, with error = 1 and is_write = 1.

Source files
------------

// File: rtl/nvdla_glb_pkg.sv
// Shared field layout, state encoding and requester IDs for the
// global-block CSB arbiter.
package nvdla_glb_pkg;

  localparam int REQ_W        = 63;
  localparam int RESP_W       = 34;
  localparam int REQ_ADDR_W   = 22;
  localparam int REQ_WDAT_LSB = 22;
  localparam int REQ_WDAT_W   = 32;
  localparam int REQ_WR_BIT   = 54;
  localparam int REQ_NP_BIT   = 55;
  localparam int RESP_RDAT_W  = 32;
  localparam int RESP_ERR_BIT = 32;
  localparam int RESP_WR_BIT  = 33;

  localparam logic HOST = 1'b0;
  localparam logic SEQ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESP
  } arb_state_t;

  // Posted writes complete on acceptance; everything else waits.
  function automatic logic needs_resp(input logic [REQ_W-1:0] pd);
    return pd[REQ_NP_BIT] | ~pd[REQ_WR_BIT];
  endfunction

  function automatic logic [RESP_W-1:0] err_resp(input logic wr);
    logic [RESP_W-1:0] r;
    r = '0;
    r[RESP_WR_BIT]  = wr;
    r[RESP_ERR_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/nvdla_glb_rr_arb2.sv
// Two-way round-robin select: on a tie the requester that was
// not granted last wins.
module nvdla_glb_rr_arb2
  import nvdla_glb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == SEQ) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/nvdla_glb_csb_arb.sv
// Arbitrates host and sequencer CSB requests onto the global block.
// NVDLA_GLB_CSB_ARB_TIMEOUT_EN adds an error response on lost replies.
module nvdla_glb_csb_arb
  import nvdla_glb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              host_req_pvld,
  output logic              host_req_prdy,
  input  logic [REQ_W-1:0]  host_req_pd,
  input  logic              seq_req_pvld,
  output logic              seq_req_prdy,
  input  logic [REQ_W-1:0]  seq_req_pd,
  output logic              csb2glb_req_pvld,
  input  logic              csb2glb_req_prdy,
  output logic [REQ_W-1:0]  csb2glb_req_pd,
  input  logic              glb2csb_resp_valid,
  input  logic [RESP_W-1:0] glb2csb_resp_pd,
  output logic              host_resp_valid,
  output logic [RESP_W-1:0] host_resp_pd,
  output logic              seq_resp_valid,
  output logic [RESP_W-1:0] seq_resp_pd,
  output logic              arb_busy
);

  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_chk
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  arb_state_t        state;
  logic              last_gnt;
  logic              owner;
  logic              csb_vld;
  logic [REQ_W-1:0]  hold_pd;
  logic [1:0]        gnt;
  logic              fwd;
  logic [RESP_W-1:0] fwd_pd;

  nvdla_glb_rr_arb2 u_rr (
    .req      ({seq_req_pvld, host_req_pvld}),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign host_req_prdy    = (state == ST_IDLE) & gnt[0];
  assign seq_req_prdy     = (state == ST_IDLE) & gnt[1];
  assign csb2glb_req_pvld = csb_vld;
  assign csb2glb_req_pd   = hold_pd;
  assign arb_busy         = (state != ST_IDLE);

`ifdef NVDLA_GLB_CSB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             tmo;

  assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // A real response in the expiry cycle takes precedence.
  always_comb begin
    fwd    = 1'b0;
    fwd_pd = glb2csb_resp_pd;
    if (state == ST_WAIT_RESP) begin
      if (glb2csb_resp_valid) begin
        fwd = 1'b1;
      end
`ifdef NVDLA_GLB_CSB_ARB_TIMEOUT_EN
      else if (tmo) begin
        fwd    = 1'b1;
        fwd_pd = err_resp(hold_pd[REQ_WR_BIT]);
      end
`endif
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state           <= ST_IDLE;
      last_gnt        <= SEQ;
      owner           <= HOST;
      csb_vld         <= 1'b0;
      hold_pd         <= '0;
      host_resp_valid <= 1'b0;
      host_resp_pd    <= '0;
      seq_resp_valid  <= 1'b0;
      seq_resp_pd     <= '0;
`ifdef NVDLA_GLB_CSB_ARB_TIMEOUT_EN
      cnt             <= '0;
`endif
    end else begin
      host_resp_valid <= 1'b0;
      seq_resp_valid  <= 1'b0;
      if (fwd) begin
        if (owner == SEQ) begin
          seq_resp_valid <= 1'b1;
          seq_resp_pd    <= fwd_pd;
        end else begin
          host_resp_valid <= 1'b1;
          host_resp_pd    <= fwd_pd;
        end
      end
      unique case (state)
        ST_IDLE: begin
          if (|gnt) begin
            hold_pd  <= gnt[1] ? seq_req_pd : host_req_pd;
            owner    <= gnt[1];
            last_gnt <= gnt[1];
            csb_vld  <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (csb2glb_req_prdy) begin
            csb_vld <= 1'b0;
            state   <= needs_resp(hold_pd) ? ST_WAIT_RESP : ST_IDLE;
`ifdef NVDLA_GLB_CSB_ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        ST_WAIT_RESP: begin
          if (fwd) begin
            state <= ST_IDLE;
          end
`ifdef NVDLA_GLB_CSB_ARB_TIMEOUT_EN
          else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvdla_glb_csb_arb.sv
// Directed bench for nvdla_glb_csb_arb; timeout scenario runs only
// when NVDLA_GLB_CSB_ARB_TIMEOUT_EN is defined.
module tb_nvdla_glb_csb_arb;

  logic        clk;
  logic        rst;
  logic        host_req_pvld;
  logic        host_req_prdy;
  logic [62:0] host_req_pd;
  logic        seq_req_pvld;
  logic        seq_req_prdy;
  logic [62:0] seq_req_pd;
  logic        csb2glb_req_pvld;
  logic        csb2glb_req_prdy;
  logic [62:0] csb2glb_req_pd;
  logic        glb2csb_resp_valid;
  logic [33:0] glb2csb_resp_pd;
  logic        host_resp_valid;
  logic [33:0] host_resp_pd;
  logic        seq_resp_valid;
  logic [33:0] seq_resp_pd;
  logic        arb_busy;

  int errors = 0;
  int checks = 0;

  nvdla_glb_csb_arb #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (11)
  ) dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rst     (rst),
    .host_req_pvld      (host_req_pvld),
    .host_req_prdy      (host_req_prdy),
    .host_req_pd        (host_req_pd),
    .seq_req_pvld       (seq_req_pvld),
    .seq_req_prdy       (seq_req_prdy),
    .seq_req_pd         (seq_req_pd),
    .csb2glb_req_pvld   (csb2glb_req_pvld),
    .csb2glb_req_prdy   (csb2glb_req_prdy),
    .csb2glb_req_pd     (csb2glb_req_pd),
    .glb2csb_resp_valid (glb2csb_resp_valid),
    .glb2csb_resp_pd    (glb2csb_resp_pd),
    .host_resp_valid    (host_resp_valid),
    .host_resp_pd       (host_resp_pd),
    .seq_resp_valid     (seq_resp_valid),
    .seq_resp_pd        (seq_resp_pd),
    .arb_busy           (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [62:0] mk_req(input logic np, input logic wr,
                                         input logic [31:0] wdat,
                                         input logic [21:0] addr);
    return {7'b0, np, wr, wdat, addr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    host_req_pvld = 1'b0;
    seq_req_pvld = 1'b0;
    host_req_pd = '0;
    seq_req_pd = '0;
    csb2glb_req_prdy = 1'b0;
    glb2csb_resp_valid = 1'b0;
    glb2csb_resp_pd = '0;
    tick();
    tick();
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", arb_busy);
    end
    checks++;
    if (csb2glb_req_pvld !== 1'b0 || csb2glb_req_pd !== 63'h0) begin
      errors++;
      $display("FAIL rst_csb got %b/%h want 0/0", csb2glb_req_pvld, csb2glb_req_pd);
    end
    checks++;
    if ({host_resp_valid, seq_resp_valid, host_resp_pd, seq_resp_pd} !== 70'h0) begin
      errors++;
      $display("FAIL rst_resp got %b %b %h %h want all 0",
               host_resp_valid, seq_resp_valid, host_resp_pd, seq_resp_pd);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_host_read();
    logic [62:0] pd;
    pd = mk_req(1'b0, 1'b0, 32'h0, 22'h000004);
    host_req_pd = pd;
    host_req_pvld = 1'b1;
    csb2glb_req_prdy = 1'b1;
    #1;
    checks++;
    if (host_req_prdy !== 1'b1 || seq_req_prdy !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant got h%b s%b want h1 s0", host_req_prdy, seq_req_prdy);
    end
    tick();
    host_req_pvld = 1'b0;
    checks++;
    if (csb2glb_req_pvld !== 1'b1 || csb2glb_req_pd !== pd || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_issue got v%b pd%h b%b want v1 pd%h b1",
               csb2glb_req_pvld, csb2glb_req_pd, arb_busy, pd);
    end
    tick();
    checks++;
    if (csb2glb_req_pvld !== 1'b0 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_wait got v%b b%b want v0 b1", csb2glb_req_pvld, arb_busy);
    end
    tick();
    tick();
    glb2csb_resp_valid = 1'b1;
    glb2csb_resp_pd = {1'b0, 1'b0, 32'hDEADBEEF};
    tick();
    glb2csb_resp_valid = 1'b0;
    checks++;
    if (host_resp_valid !== 1'b1 || host_resp_pd[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_resp got v%b d%h want v1 dDEADBEEF", host_resp_valid, host_resp_pd[31:0]);
    end
    checks++;
    if (seq_resp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_seq_quiet got %b want 0", seq_resp_valid);
    end
    tick();
    checks++;
    if (host_resp_valid !== 1'b0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_done got v%b b%b want v0 b0", host_resp_valid, arb_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [62:0] hpd;
    logic [62:0] spd;
    logic        exp_h;
    logic        exp_s;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hpd = mk_req(1'b0, 1'b1, 32'h11111111, 22'h000010);
    spd = mk_req(1'b0, 1'b1, 32'h22222222, 22'h000020);
    host_req_pd = hpd;
    seq_req_pd = spd;
    host_req_pvld = 1'b1;
    seq_req_pvld = 1'b1;
    csb2glb_req_prdy = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_h = (k % 4) == 0;
      exp_s = (k % 4) == 2;
      checks++;
      if (host_req_prdy !== exp_h || seq_req_prdy !== exp_s) begin
        errors++;
        $display("FAIL b2b_grant[%0d] got h%b s%b want h%b s%b",
                 k, host_req_prdy, seq_req_prdy, exp_h, exp_s);
      end
      if (k % 2 == 1) begin
        checks++;
        if (csb2glb_req_pd !== (((k % 4) == 1) ? hpd : spd)) begin
          errors++;
          $display("FAIL b2b_pd[%0d] got %h want %h", k, csb2glb_req_pd,
                   ((k % 4) == 1) ? hpd : spd);
        end
      end
      tick();
    end
    host_req_pvld = 1'b0;
    seq_req_pvld = 1'b0;
  endtask

  task automatic test_stall();
    logic [62:0] spd;
    spd = mk_req(1'b1, 1'b1, 32'hCAFEF00D, 22'h000030);
    seq_req_pd = spd;
    seq_req_pvld = 1'b1;
    csb2glb_req_prdy = 1'b0;
    tick();
    seq_req_pvld = 1'b0;
    host_req_pvld = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (csb2glb_req_pvld !== 1'b1 || csb2glb_req_pd !== spd ||
          host_req_prdy !== 1'b0 || seq_req_prdy !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d] got v%b pd%h h%b s%b want v1 pd%h h0 s0", i,
                 csb2glb_req_pvld, csb2glb_req_pd, host_req_prdy, seq_req_prdy, spd);
      end
      tick();
    end
    host_req_pvld = 1'b0;
    csb2glb_req_prdy = 1'b1;
    tick();
    glb2csb_resp_valid = 1'b1;
    glb2csb_resp_pd = {1'b1, 1'b0, 32'h0};
    tick();
    glb2csb_resp_valid = 1'b0;
    checks++;
    if (seq_resp_valid !== 1'b1 || host_resp_valid !== 1'b0 || seq_resp_pd[33] !== 1'b1) begin
      errors++;
      $display("FAIL stall_resp got s%b h%b w%b want s1 h0 w1",
               seq_resp_valid, host_resp_valid, seq_resp_pd[33]);
    end
    tick();
  endtask

  task automatic test_spurious();
    glb2csb_resp_valid = 1'b1;
    glb2csb_resp_pd = {1'b0, 1'b0, 32'h12345678};
    tick();
    tick();
    glb2csb_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (host_resp_valid !== 1'b0 || seq_resp_valid !== 1'b0 || arb_busy !== 1'b0) begin
        errors++;
        $display("FAIL spurious[%0d] got h%b s%b b%b want 0 0 0",
                 i, host_resp_valid, seq_resp_valid, arb_busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    host_req_pd = mk_req(1'b0, 1'b0, 32'h0, 22'h000040);
    host_req_pvld = 1'b1;
    csb2glb_req_prdy = 1'b1;
    tick();
    host_req_pvld = 1'b0;
    tick();
    checks++;
    if (arb_busy !== 1'b1 || csb2glb_req_pvld !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait got b%b v%b want b1 v0", arb_busy, csb2glb_req_pvld);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++; $display("FAIL mid_async got %b want 0", arb_busy);
    end
    tick();
    rst = 1'b0;
    tick();
    glb2csb_resp_valid = 1'b1;
    glb2csb_resp_pd = {1'b0, 1'b0, 32'hBAADF00D};
    tick();
    glb2csb_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (host_resp_valid !== 1'b0 || seq_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_drop[%0d] got h%b s%b want 0 0", i, host_resp_valid, seq_resp_valid);
      end
      tick();
    end
    host_req_pvld = 1'b1;
    seq_req_pvld = 1'b1;
    #1;
    checks++;
    if (host_req_prdy !== 1'b1 || seq_req_prdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_first got h%b s%b want h1 s0", host_req_prdy, seq_req_prdy);
    end
    tick();
    host_req_pvld = 1'b0;
    seq_req_pvld = 1'b0;
    tick();
    glb2csb_resp_valid = 1'b1;
    tick();
    glb2csb_resp_valid = 1'b0;
    tick();
  endtask

`ifdef NVDLA_GLB_CSB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    seq_req_pd = mk_req(1'b1, 1'b1, 32'h55AA55AA, 22'h000050);
    seq_req_pvld = 1'b1;
    csb2glb_req_prdy = 1'b1;
    tick();
    seq_req_pvld = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (seq_resp_valid !== 1'b0) early++;
      tick();
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL tmo_early got %0d pulses want 0", early);
    end
    checks++;
    if (seq_resp_valid !== 1'b1 || host_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_valid got s%b h%b want s1 h0", seq_resp_valid, host_resp_valid);
    end
    checks++;
    if (seq_resp_pd !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL tmo_pd got %h want %h", seq_resp_pd, {1'b1, 1'b1, 32'h0});
    end
    tick();
    checks++;
    if (arb_busy !== 1'b0 || seq_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle got b%b s%b want 0 0", arb_busy, seq_resp_valid);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_host_read();
    test_back_to_back();
    test_stall();
    test_spurious();
    test_reset_mid();
`ifdef NVDLA_GLB_CSB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
